// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared defaults and FSM state encoding for the fir stream
//               feeder and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    // Default geometry of the sample BRAM and stream
    localparam int P_ADDR_WIDTH = 12;
    localparam int P_DATA_WIDTH = 32;
    localparam int P_LEN_WIDTH  = 32;

    // Word index to byte address: word i lives at byte 4*i
    localparam int BYTE_SHIFT   = 2;

    // Feeder control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/fir_ss_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_ss_feeder_if
// Description : AXI-Stream beat channel between the feeder (master) and the
//               fir ss_* slave port.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_ss_feeder_if #(
    parameter int pDATA_WIDTH = 32
) ();

    logic                   ss_tvalid;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   ss_tready;

    // Feeder side: drives the beat, receives back-pressure
    modport master (
        output ss_tvalid,
        output ss_tdata,
        output ss_tlast,
        input  ss_tready
    );

    // fir side: consumes the beat, drives back-pressure
    modport slave (
        input  ss_tvalid,
        input  ss_tdata,
        input  ss_tlast,
        output ss_tready
    );

endinterface
`default_nettype wire

// File: rtl/fir_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : fir_skid_fifo2
// Description : Two-entry FIFO holding {tlast,data} words between the BRAM
//               read pipeline and the stream port. Head is presented
//               combinationally; push and pop in the same cycle are allowed.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_skid_fifo2 #(
    parameter int WIDTH = 33
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic      [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    // Next-state: qualify push/pop against occupancy, advance pointers/count
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);
        // A push into a full FIFO is only legal when the head leaves this cycle;
        // the write then lands in the slot the head vacates.
        do_push  = push && ((count_q != 2'd2) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset empties the FIFO and zeroes the head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fir_ss_feeder.sv
`default_nettype none
// ============================================================================
// Module      : fir_ss_feeder
// Description : Streams `length` samples from a 1-cycle-latency sample BRAM
//               into fir's AXI-Stream slave port, tagging the final beat with
//               tlast. Sustains one beat per cycle under full ready.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_ss_feeder
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = P_ADDR_WIDTH,
    parameter int pDATA_WIDTH = P_DATA_WIDTH,
    parameter int pLEN_WIDTH  = P_LEN_WIDTH
) (
    input  wire logic                   axis_clk,
    input  wire logic                   axis_rst_n,
    input  wire logic                   start,
    input  wire logic [pLEN_WIDTH-1:0]  length,
    output logic                        busy,
    output logic                        done,
    output logic                        src_EN,
    output logic      [3:0]             src_WE,
    output logic      [pADDR_WIDTH-1:0] src_A,
    input  wire logic [pDATA_WIDTH-1:0] src_Do,
    fir_ss_feeder_if.master             ss
);

    localparam logic [pLEN_WIDTH-1:0] LEN_ONE = {{(pLEN_WIDTH-1){1'b0}}, 1'b1};

    feeder_state_t          state_q,    state_d;
    logic [pLEN_WIDTH-1:0]  rd_idx_q,   rd_idx_d;
    logic [pLEN_WIDTH-1:0]  len_q,      len_d;
    logic [pLEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                   inflight_q, inflight_d;
    logic                   tag_q,      tag_d;

    logic [pDATA_WIDTH:0]   fifo_dout;
    logic [1:0]             fifo_count;
    logic [1:0]             occupancy;
    logic                   tvalid;
    logic                   pop;
    logic                   rd_en;
    logic                   last_rd;
    logic                   last_beat;
    logic [pLEN_WIDTH-1:0]  byte_addr;

    // Stream side: head of the FIFO is the current beat
    assign tvalid       = (fifo_count != 2'd0);
    assign pop          = tvalid && ss.ss_tready;
    assign ss.ss_tvalid = tvalid;
    assign ss.ss_tdata  = fifo_dout[pDATA_WIDTH-1:0];
    assign ss.ss_tlast  = fifo_dout[pDATA_WIDTH];

    // Read issue: entries held after this cycle's pop plus the read already in
    // flight must leave room for one more word. Counting the departing beat is
    // what lets a read issue every cycle while ready stays high.
    always_comb begin
        occupancy = fifo_count + {1'b0, inflight_q} - {1'b0, pop};
        rd_en     = (state_q == ST_RUN) && (occupancy < 2'd2);
        last_rd   = (rd_idx_q == (len_q - LEN_ONE));
        last_beat = (beat_cnt_q == (len_q - LEN_ONE));
        byte_addr = rd_idx_q << BYTE_SHIFT;
    end

    // FSM next state plus index, counter and read-pipeline bookkeeping
    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        inflight_d = rd_en;
        tag_d      = rd_en && last_rd;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d      = length;
                    rd_idx_d   = '0;
                    beat_cnt_d = '0;
                    state_d    = (length == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_en) begin
                    rd_idx_d = rd_idx_q + LEN_ONE;
                    if (last_rd) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && last_beat) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (pop) begin
            beat_cnt_d = beat_cnt_q + LEN_ONE;
        end
    end

    // Control registers; reset aborts any transfer without a done pulse
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= ST_IDLE;
            rd_idx_q   <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            inflight_q <= 1'b0;
            tag_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    // Read data returns one cycle after issue and is captured with its tlast tag
    fir_skid_fifo2 #(
        .WIDTH (pDATA_WIDTH + 1)
    ) u_fifo (
        .clk   (axis_clk),
        .rst_n (axis_rst_n),
        .push  (inflight_q),
        .pop   (pop),
        .din   ({tag_q, src_Do}),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_FIN);
    assign src_EN = rd_en;
    assign src_WE = 4'b0000;
    assign src_A  = rd_en ? byte_addr[pADDR_WIDTH-1:0] : '0;

endmodule
`default_nettype wire
